// File: rtl/vfirst_scan_if.sv
// vfirst_scan_if: mask-beat input stream and scalar result bus for vfirst_scan.
interface vfirst_scan_if #(
    parameter int RESP_DATA_WIDTH = 64,
    parameter int REQ_ADDR_WIDTH  = 32,
    parameter int XLEN            = 32
);
    logic                       in_valid;
    logic                       in_first;
    logic                       in_last;
    logic [RESP_DATA_WIDTH-1:0] in_vec;
    logic [RESP_DATA_WIDTH-1:0] in_en;
    logic [REQ_ADDR_WIDTH-1:0]  in_addr;
    logic                       out_valid;
    logic [XLEN-1:0]            out_data;
    logic [REQ_ADDR_WIDTH-1:0]  out_addr;
    modport master (
        output in_valid, in_first, in_last, in_vec, in_en, in_addr,
        input  out_valid, out_data, out_addr
    );
    modport slave (
        input  in_valid, in_first, in_last, in_vec, in_en, in_addr,
        output out_valid, out_data, out_addr
    );
endinterface

// File: rtl/vfirst_scan.sv
// vfirst_scan: finds the index of the first enabled set mask element across a multi-beat instruction.
// Pipeline: stage A registers per-beat hit/lowest index, stage B accumulates, output stage registers the result.
module vfirst_scan #(
    parameter int RESP_DATA_WIDTH = 64,
    parameter int REQ_ADDR_WIDTH  = 32,
    parameter int XLEN            = 32
) (
    input logic          clk,
    input logic          rst,
    vfirst_scan_if.slave bus
);
    localparam int LW = $clog2(RESP_DATA_WIDTH);
    typedef enum logic {IDLE, ACTIVE} state_t;
    logic [RESP_DATA_WIDTH-1:0] masked;
    logic [LW-1:0]              lidx, a_lidx;
    logic                       a_valid, a_first, a_last, a_hit;
    logic [REQ_ADDR_WIDTH-1:0]  a_addr, addr, addr_n;
    state_t                     state, state_n;
    logic [XLEN-1:0]            base, base_n, result, result_n, eff_base;
    logic                       found, found_n, eff_found, done, done_n, proc;
    assign masked = bus.in_vec & bus.in_en;
    always_comb begin
        lidx = '0;
        for (int i = RESP_DATA_WIDTH - 1; i >= 0; i--)
            if (masked[i]) lidx = LW'(i);
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            a_valid <= 1'b0;
            a_first <= 1'b0;
            a_last  <= 1'b0;
            a_hit   <= 1'b0;
            a_lidx  <= '0;
            a_addr  <= '0;
        end else begin
            a_valid <= bus.in_valid;
            a_first <= bus.in_valid & bus.in_first;
            a_last  <= bus.in_valid & bus.in_last;
            a_hit   <= bus.in_valid & (|masked);
            a_lidx  <= bus.in_valid ? lidx : '0;
            if (bus.in_valid & bus.in_first) a_addr <= bus.in_addr;
        end
    end
    // A first beat restarts the scan from scratch, even over an unfinished instruction.
    always_comb begin
        proc      = a_valid && (a_first || state == ACTIVE);
        eff_base  = a_first ? '0 : base;
        eff_found = a_first ? 1'b0 : found;
        state_n   = proc ? (a_last ? IDLE : ACTIVE) : state;
        base_n    = proc ? eff_base + XLEN'(RESP_DATA_WIDTH) : base;
        found_n   = proc ? (eff_found | a_hit) : found;
        result_n  = (proc && !eff_found && a_hit) ? eff_base + XLEN'(a_lidx) : result;
        addr_n    = (proc && a_first) ? a_addr : addr;
        done_n    = proc && a_last;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            base   <= '0;
            found  <= 1'b0;
            result <= '0;
            addr   <= '0;
            done   <= 1'b0;
        end else begin
            state  <= state_n;
            base   <= base_n;
            found  <= found_n;
            result <= result_n;
            addr   <= addr_n;
            done   <= done_n;
        end
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            bus.out_valid <= 1'b0;
            bus.out_data  <= '0;
            bus.out_addr  <= '0;
        end else begin
            bus.out_valid <= done;
            if (done) begin
                bus.out_data <= found ? result : '1;
                bus.out_addr <= addr;
            end
        end
    end
endmodule
